// File: rtl/scanner_ui_pkg.sv
// Shared front-panel types and default timing constants: FSM state encoding,
// button direction, and the hold/repeat/step defaults used by the UI blocks.
package scanner_ui_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [23:0] HOLD_CYCLES_DEF   = 24'd16_000_000;
    localparam logic [23:0] REPEAT_CYCLES_DEF = 24'd3_000_000;
    localparam logic [9:0]  FINE_STEP_DEF     = 10'd1;
    localparam logic [9:0]  COARSE_STEP_DEF   = 10'd16;
    localparam int          ACCEL_COUNT_DEF   = 8;

endpackage

// File: rtl/cycle_timer.sv
// 24-bit interval counter: cleared to zero by clear, counts while enabled and
// wraps back to zero on the cycle it reaches the programmable terminal count.
module cycle_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [23:0] terminal,
    output logic        hit
);

    logic [23:0] count;

    assign hit = (count == terminal);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= 24'd0;
        end else if (enable) begin
            count <= hit ? 24'd0 : count + 24'd1;
        end
    end

endmodule

// File: rtl/step_pulser.sv
// Button-to-strobe generator: one strobe per press plus timed auto-repeat while
// held. Define REPEAT_ACCEL_EN to switch step to COARSE_STEP after ACCEL_COUNT repeats.
module step_pulser
    import scanner_ui_pkg::*;
#(
    parameter logic [23:0] HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter logic [23:0] REPEAT_CYCLES = REPEAT_CYCLES_DEF,
    parameter logic [9:0]  FINE_STEP     = FINE_STEP_DEF,
    parameter logic [9:0]  COARSE_STEP   = COARSE_STEP_DEF,
    parameter int          ACCEL_COUNT   = ACCEL_COUNT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       up_in,
    input  logic       down_in,
    output logic       increment,
    output logic       decrement,
    output logic [9:0] step
);

    if (HOLD_CYCLES < 24'd2 || REPEAT_CYCLES < 24'd2 || ACCEL_COUNT < 1 ||
        FINE_STEP == 10'd0 || COARSE_STEP == 10'd0) begin : g_param_check
        $error("step_pulser: HOLD/REPEAT_CYCLES must be >= 2, ACCEL_COUNT >= 1, steps nonzero");
    end

    logic   up_q;
    logic   down_q;
    state_t state;
    state_t state_next;
    dir_t   dir;
    dir_t   fire_dir;
    logic   fire;
    logic   timer_hit;
    logic   press_up;
    logic   press_down;
    logic   abort;
    logic [23:0] terminal;

    assign press_up   = up_in & ~up_q;
    assign press_down = down_in & ~down_q;
    // Releasing the held button or touching the opposite one ends the hold.
    assign abort    = (dir == DIR_UP) ? (~up_in | down_in) : (~down_in | up_in);
    assign terminal = (state == ST_HOLD) ? (HOLD_CYCLES - 24'd1) : (REPEAT_CYCLES - 24'd1);

    cycle_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (state == ST_IDLE),
        .enable   (state != ST_IDLE),
        .terminal (terminal),
        .hit      (timer_hit)
    );

    always_comb begin
        state_next = state;
        fire       = 1'b0;
        fire_dir   = dir;
        case (state)
            ST_IDLE: begin
                if (press_up ^ press_down) begin
                    state_next = ST_HOLD;
                    fire       = 1'b1;
                    fire_dir   = press_up ? DIR_UP : DIR_DOWN;
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (timer_hit) begin
                    state_next = ST_REPEAT;
                    fire       = 1'b1;
                end
            end
            ST_REPEAT: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (timer_hit) begin
                    fire = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Input registers reset high so a button held through reset needs a re-press.
    always_ff @(posedge clk) begin
        if (reset) begin
            up_q      <= 1'b1;
            down_q    <= 1'b1;
            state     <= ST_IDLE;
            dir       <= DIR_UP;
            increment <= 1'b0;
            decrement <= 1'b0;
        end else begin
            up_q      <= up_in;
            down_q    <= down_in;
            state     <= state_next;
            dir       <= fire_dir;
            increment <= fire && (fire_dir == DIR_UP);
            decrement <= fire && (fire_dir == DIR_DOWN);
        end
    end

`ifdef REPEAT_ACCEL_EN
    localparam int RW = $clog2(ACCEL_COUNT + 1);
    localparam logic [RW-1:0] ACCEL_MAX  = RW'(ACCEL_COUNT);
    localparam logic [RW-1:0] ACCEL_LAST = RW'(ACCEL_COUNT - 1);

    logic [RW-1:0] rpt_cnt;

    // The hold-expiry strobe is repeat #1; rpt_cnt counts the repeats after it,
    // so a REPEAT-state strobe is number rpt_cnt+2 and goes coarse past ACCEL_COUNT.
    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_cnt <= '0;
            step    <= FINE_STEP;
        end else if (state_next == ST_IDLE) begin
            step <= FINE_STEP;
        end else if (fire) begin
            if (state == ST_REPEAT) begin
                step <= (rpt_cnt >= ACCEL_LAST) ? COARSE_STEP : FINE_STEP;
                if (rpt_cnt != ACCEL_MAX) begin
                    rpt_cnt <= rpt_cnt + 1'b1;
                end
            end else begin
                step    <= FINE_STEP;
                rpt_cnt <= '0;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        step <= FINE_STEP;
    end
`endif

endmodule

// File: tb/tb_step_pulser.sv
// Directed bench for step_pulser with HOLD_CYCLES=10, REPEAT_CYCLES=4, ACCEL_COUNT=2;
// expected {increment, decrement, step} per cycle is queued as stimulus is driven.
module tb_step_pulser;

    logic       clk = 1'b0;
    logic       reset;
    logic       up_in;
    logic       down_in;
    logic       increment;
    logic       decrement;
    logic [9:0] step;

    logic [11:0] exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    string       tag = "reset";

    always #5 clk = ~clk;

    step_pulser #(
        .HOLD_CYCLES   (24'd10),
        .REPEAT_CYCLES (24'd4),
        .FINE_STEP     (10'd1),
        .COARSE_STEP   (10'd16),
        .ACCEL_COUNT   (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .up_in     (up_in),
        .down_in   (down_in),
        .increment (increment),
        .decrement (decrement),
        .step      (step)
    );

    function automatic logic [11:0] pack(input logic inc, input logic dec, input logic [9:0] s);
        return {inc, dec, s};
    endfunction

    // Step expected during the long up-hold, c = output cycle number.
    function automatic logic [9:0] hold_step(input int c);
`ifdef REPEAT_ACCEL_EN
        return (c >= 19 && c <= 30) ? 10'd16 : 10'd1;
`else
        return (c >= 0) ? 10'd1 : 10'd1;
`endif
    endfunction

    task automatic check_out();
        logic [11:0] exp;
        logic [11:0] obs;
        exp = exp_q.pop_front();
        obs = {increment, decrement, step};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed inc=%b dec=%b step=%0d expected inc=%b dec=%b step=%0d",
                   tag, cyc, obs[11], obs[10], obs[9:0], exp[11], exp[10], exp[9:0]);
        end
    endtask

    // Drive inputs for edge k, queue expected outputs of cycle k+1, compare after the edge.
    task automatic step_cycle(input logic u, input logic d, input logic r, input logic [11:0] exp);
        up_in   = u;
        down_in = d;
        reset   = r;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        cyc++;
        check_out();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step_cycle(1'b0, 1'b0, 1'b0, pack(1'b0, 1'b0, 10'd1));
    endtask

    initial begin
        up_in   = 1'b0;
        down_in = 1'b0;
        reset   = 1'b1;

        step_cycle(1'b0, 1'b0, 1'b1, pack(1'b0, 1'b0, 10'd1));
        step_cycle(1'b0, 1'b0, 1'b1, pack(1'b0, 1'b0, 10'd1));
        idle(3);

        tag = "single";
        cyc = 0;
        step_cycle(1'b1, 1'b0, 1'b0, pack(1'b1, 1'b0, 10'd1));
        idle(5);

        tag = "hold";
        cyc = 0;
        for (int k = 0; k <= 34; k++) begin
            int c;
            logic inc;
            c = k + 1;
            inc = (c == 1 || c == 11 || c == 15 || c == 19 || c == 23 || c == 27);
            step_cycle(k <= 29, 1'b0, 1'b0, pack(inc, 1'b0, hold_step(c)));
        end
        idle(3);

        tag = "both";
        cyc = 0;
        for (int k = 0; k < 20; k++) step_cycle(1'b1, 1'b1, 1'b0, pack(1'b0, 1'b0, 10'd1));
        idle(4);

        tag = "reset_hold";
        cyc = 0;
        for (int k = 0; k <= 40; k++) begin
            step_cycle(1'b0, 1'b1, k == 5, pack(1'b0, k == 0, 10'd1));
        end
        idle(3);
        tag = "repress";
        step_cycle(1'b0, 1'b1, 1'b0, pack(1'b0, 1'b1, 10'd1));
        idle(3);

        tag = "opposite";
        cyc = 0;
        for (int k = 0; k <= 20; k++) begin
            int c;
            c = k + 1;
            step_cycle(k <= 13, k >= 12, 1'b0, pack(c == 1 || c == 11, 1'b0, 10'd1));
        end
        idle(3);
        tag = "opp_repress";
        step_cycle(1'b0, 1'b1, 1'b0, pack(1'b0, 1'b1, 10'd1));
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
